// File: rtl/fp_cmp64_sched.sv
// Shared IEEE-754 double comparator. NREQ requesters are arbitrated round-robin
// into a two-stage pipeline (operand register S1, result register S2) that
// drives one tagged response port. Also keeps a response counter and a sticky
// NaN flag.
module fp_cmp64_sched #(
    parameter int NREQ = 4,
    parameter int TAGW = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*64-1:0]         req_a,
    input  logic [NREQ*64-1:0]         req_b,
    input  logic [NREQ*TAGW-1:0]       req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [TAGW-1:0]            rsp_tag,
    output logic [15:0]                rsp_flags,
    output logic                       rsp_nan,
    output logic                       rsp_snan,
    output logic                       nan_sticky,
    input  logic                       clr_sticky,
    output logic [31:0]                ops_done,
    output logic                       busy
);
    localparam int IDW = $clog2(NREQ);

    logic            r_s1_valid, r_s2_valid;
    logic [63:0]     r_s1_a, r_s1_b;
    logic [TAGW-1:0] r_s1_tag;
    logic [IDW-1:0]  r_s1_id;
    logic [IDW-1:0]  r_ptr;

    logic            w_adv1, w_adv2;
    logic            w_gnt_found, w_accept;
    logic [IDW-1:0]  w_gnt;

    assign w_adv2   = !r_s2_valid || rsp_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_accept = w_gnt_found && w_adv1;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        logic [IDW-1:0] v_idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_gnt_found = 1'b0;
        w_gnt       = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_gnt_found && req_valid[v_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt       = v_idx;
            end
        end
    end

    // Only the granted requester sees ready; it follows pipeline advance.
    always_comb begin
        req_ready = '0;
        if (w_gnt_found) req_ready[w_gnt] = w_adv1;
    end

    // Arbitration pointer moves past the winner only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n)        r_ptr <= '0;
        else if (w_accept) r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
    end

    // Operand stage: capture the granted request when the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so the response fields
        // read as zero after reset instead of stale operands.
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
            r_s1_id    <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= req_a[64*int'(w_gnt) +: 64];
                r_s1_b   <= req_b[64*int'(w_gnt) +: 64];
                r_s1_tag <= req_tag[TAGW*int'(w_gnt) +: TAGW];
                r_s1_id  <= w_gnt;
            end
        end
    end

    // Compare datapath on the S1 operands.
    logic        w_zero_a, w_zero_b, w_nan_a, w_nan_b, w_snan;
    logic        w_unord, w_eq, w_mlt, w_mgt, w_lt;
    logic [4:0]  w_vec;
    logic [15:0] w_flags;

    assign w_zero_a = (r_s1_a[62:0] == 63'd0);
    assign w_zero_b = (r_s1_b[62:0] == 63'd0);
    assign w_nan_a  = (&r_s1_a[62:52]) && (|r_s1_a[51:0]);
    assign w_nan_b  = (&r_s1_b[62:52]) && (|r_s1_b[51:0]);
    assign w_snan   = (w_nan_a && !r_s1_a[51]) || (w_nan_b && !r_s1_b[51]);
    assign w_unord  = w_nan_a || w_nan_b;
    assign w_eq     = !w_unord && ((r_s1_a == r_s1_b) || (w_zero_a && w_zero_b));
    assign w_mlt    = !w_unord && (r_s1_a[62:0] < r_s1_b[62:0]);
    assign w_mgt    = r_s1_b[62:0] < r_s1_a[62:0];
    assign w_lt     = !w_unord &&
                      ((r_s1_a[63] != r_s1_b[63]) ? (r_s1_a[63] && !(w_zero_a && w_zero_b))
                                                  : (r_s1_a[63] ? w_mgt : w_mlt));
    assign w_vec    = {w_unord, w_mlt, w_lt || w_eq, w_lt, w_eq};
    assign w_flags  = {3'b000, ~w_vec, 3'b000, w_vec};

    // Result stage: load from S1 whenever the response slot can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            rsp_flags  <= '0;
            rsp_nan    <= 1'b0;
            rsp_snan   <= 1'b0;
            rsp_id     <= '0;
            rsp_tag    <= '0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            rsp_flags  <= w_flags;
            rsp_nan    <= w_unord;
            rsp_snan   <= w_snan;
            rsp_id     <= r_s1_id;
            rsp_tag    <= r_s1_tag;
        end
    end

    // Accepted-response counter and sticky NaN flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done   <= '0;
            nan_sticky <= 1'b0;
        end else begin
            if (r_s2_valid && rsp_ready) ops_done <= ops_done + 32'd1;
            if (r_s2_valid && rsp_ready && rsp_nan) nan_sticky <= 1'b1;
            else if (clr_sticky)                    nan_sticky <= 1'b0;
        end
    end

    assign rsp_valid = r_s2_valid;
    assign busy      = r_s1_valid || r_s2_valid;
endmodule

// File: tb/tb_fp_cmp64_sched.sv
// Directed bench for fp_cmp64_sched with hand-computed expected values.
module tb_fp_cmp64_sched;
    localparam int NREQ = 4;
    localparam int TAGW = 4;
    localparam int IDW  = 2;

    localparam logic [63:0] P1 = 64'h3FF0000000000000;
    localparam logic [63:0] P2 = 64'h4000000000000000;
    localparam logic [63:0] N1 = 64'hBFF0000000000000;
    localparam logic [63:0] N2 = 64'hC000000000000000;
    localparam logic [63:0] QN = 64'h7FF8000000000000;
    localparam logic [63:0] SN = 64'h7FF0000000000001;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*64-1:0]   req_a, req_b;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [TAGW-1:0]      rsp_tag;
    logic [15:0]          rsp_flags;
    logic                 rsp_nan, rsp_snan, nan_sticky, clr_sticky, busy;
    logic [31:0]          ops_done;

    int n_checks = 0;
    int n_errors = 0;

    fp_cmp64_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
        .rsp_nan(rsp_nan), .rsp_snan(rsp_snan),
        .nan_sticky(nan_sticky), .clr_sticky(clr_sticky),
        .ops_done(ops_done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [TAGW-1:0] t);
        req_a[i*64 +: 64]     = a;
        req_b[i*64 +: 64]     = b;
        req_tag[i*TAGW +: TAGW] = t;
    endtask

    // Single request on an idle pipeline; returns with its response on rsp_*.
    task automatic issue(input string nm, input int i, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAGW-1:0] t);
        set_req(i, a, b, t);
        req_valid = NREQ'(1) << i;
        #1;
        check({nm, "_ready"}, 64'(req_ready), 64'(NREQ'(1) << i));
        tick;
        req_valid = '0;
        check({nm, "_lat1_valid"}, 64'(rsp_valid), 64'd0);
        tick;
        check({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        check({nm, "_id"}, 64'(rsp_id), 64'(i));
        check({nm, "_tag"}, 64'(rsp_tag), 64'(t));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b1; clr_sticky = 1'b0;
        #12;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ops", 64'(ops_done), 64'd0);
        check("rst_sticky", 64'(nan_sticky), 64'd0);
        check("rst_flags", 64'(rsp_flags), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        tick;

        // 1.0 vs 2.0
        issue("one_two", 0, P1, P2, 4'd5);
        check("one_two_flags", 64'(rsp_flags), 64'h110E);
        check("one_two_nan", 64'(rsp_nan), 64'd0);
        check("one_two_snan", 64'(rsp_snan), 64'd0);
        tick;
        check("one_two_ops", 64'(ops_done), 64'd1);
        check("one_two_drained", 64'(rsp_valid), 64'd0);

        // +0 vs -0
        issue("zeros", 2, 64'h0, 64'h8000000000000000, 4'd7);
        check("zeros_flags", 64'(rsp_flags), 64'h1A05);
        tick;

        // -2.0 vs -1.0 : negative same-sign ordering
        issue("negs", 3, N2, N1, 4'd9);
        check("negs_flags", 64'(rsp_flags), 64'h1906);
        tick;

        // quiet NaN
        issue("qnan", 1, QN, P1, 4'd3);
        check("qnan_flags", 64'(rsp_flags), 64'h0F10);
        check("qnan_nan", 64'(rsp_nan), 64'd1);
        check("qnan_snan", 64'(rsp_snan), 64'd0);
        check("qnan_sticky_before", 64'(nan_sticky), 64'd0);
        tick;
        check("qnan_sticky", 64'(nan_sticky), 64'd1);
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        check("sticky_cleared", 64'(nan_sticky), 64'd0);

        // signalling NaN, clear collides with set
        issue("snan", 1, SN, P1, 4'd4);
        check("snan_flags", 64'(rsp_flags), 64'h0F10);
        check("snan_nan", 64'(rsp_nan), 64'd1);
        check("snan_snan", 64'(rsp_snan), 64'd1);
        clr_sticky = 1'b1;
        tick;
        clr_sticky = 1'b0;
        check("set_beats_clear", 64'(nan_sticky), 64'd1);
        check("ops_five", 64'(ops_done), 64'd5);

        // All four requesters continuously valid from a fresh pointer
        do_reset;
        for (int i = 0; i < NREQ; i++) set_req(i, P1, P2, TAGW'(8 + i));
        req_valid = '1;
        #1;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(NREQ'(1) << (c % NREQ)));
            if (c >= 2) begin
                check($sformatf("rr_valid%0d", c), 64'(rsp_valid), 64'd1);
                check($sformatf("rr_id%0d", c), 64'(rsp_id), 64'((c - 2) % NREQ));
                check($sformatf("rr_tag%0d", c), 64'(rsp_tag), 64'(8 + (c - 2) % NREQ));
            end
            tick;
        end
        req_valid = '0;
        check("rr_id6", 64'(rsp_id), 64'd2);
        tick;
        check("rr_id7", 64'(rsp_id), 64'd3);
        tick;
        check("rr_empty", 64'(rsp_valid), 64'd0);
        check("rr_ops", 64'(ops_done), 64'd8);

        // Backpressure: requesters 0 and 3, response port stalled
        set_req(0, P2, P1, 4'd1);
        set_req(3, N1, P1, 4'd6);
        rsp_ready = 1'b0;
        req_valid = 4'b1001;
        #1;
        check("bp_grant0", 64'(req_ready), 64'b0001);
        tick;
        check("bp_grant3", 64'(req_ready), 64'b1000);
        tick;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
            check($sformatf("bp_id%0d", c), 64'(rsp_id), 64'd0);
            check($sformatf("bp_flags%0d", c), 64'(rsp_flags), 64'h1F00);
            check($sformatf("bp_tag%0d", c), 64'(rsp_tag), 64'd1);
            check($sformatf("bp_ops%0d", c), 64'(ops_done), 64'd8);
            tick;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("drain0_id", 64'(rsp_id), 64'd0);
        tick;
        check("drain1_valid", 64'(rsp_valid), 64'd1);
        check("drain1_id", 64'(rsp_id), 64'd3);
        check("drain1_flags", 64'(rsp_flags), 64'h1906);
        check("drain1_tag", 64'(rsp_tag), 64'd6);
        tick;
        check("drain_empty", 64'(rsp_valid), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_ops", 64'(ops_done), 64'd10);

        // Reset while both stages are full
        issue("pre_rst_nan", 2, P1, QN, 4'd2);
        tick;
        check("pre_rst_sticky", 64'(nan_sticky), 64'd1);
        set_req(0, P1, P2, 4'd1);
        set_req(1, P2, P1, 4'd2);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        tick;
        tick;
        check("full_ready", 64'(req_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ops", 64'(ops_done), 64'd0);
        check("mid_rst_sticky", 64'(nan_sticky), 64'd0);
        check("mid_rst_id", 64'(rsp_id), 64'd0);
        #1;
        rst_n = 1'b1;
        tick;
        tick;
        check("post_rst_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_ops", 64'(ops_done), 64'd0);
        req_valid = '1;
        #1;
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        req_valid = '0;
        tick;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
